// File: rtl/uart_rx_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_pkg
// Purpose : Shared constants, types and helpers for the UART receiver:
//           oversample tick positions, FSM state encodings, the latched
//           frame configuration record and small helper functions.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  // Oversampling: 16 ticks per bit, line sampled at the bit centre.
  localparam logic [3:0] c_TICK_S0   = 4'd7;
  localparam logic [3:0] c_TICK_S1   = 4'd8;
  localparam logic [3:0] c_TICK_S2   = 4'd9;
  localparam logic [3:0] c_TICK_LAST = 4'd15;

  // Receiver FSM state encodings.
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP1  = 3'd4;
  localparam logic [2:0] c_ST_STOP2  = 3'd5;

  // Frame configuration captured at start-bit detection.
  typedef struct packed {
    logic [1:0] length;
    logic       stop2;
    logic       parity;
    logic       odd;
  } rx_cfg_t;

  // Number of data bits for a length code (0..3 -> 6..9).
  function automatic logic [3:0] data_bits(input logic [1:0] length);
    return {2'b00, length} + 4'd6;
  endfunction

  // Two-out-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_if
// Purpose : Bundles the UART receiver line, framing controls and received
//           word/status outputs.
// Ports   : i_ce, i_rx, i_length, i_stop2, i_parity, i_odd  (into receiver)
//           o_data, o_valid, o_parity_err, o_frame_err, o_busy (from receiver)
//           modport master = the receiver, modport slave = its environment
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if;
  logic       i_ce;
  logic       i_rx;
  logic [1:0] i_length;
  logic       i_stop2;
  logic       i_parity;
  logic       i_odd;
  logic [8:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    input  i_ce, i_rx, i_length, i_stop2, i_parity, i_odd,
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    output i_ce, i_rx, i_length, i_stop2, i_parity, i_odd,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_sampler
// Purpose : Line synchronizer, per-bit oversample tick counter and
//           three-sample majority vote for the UART receiver.
// Ports   : i_clk, i_rst_n  clock / async active-low reset
//           i_ce            16x oversample tick
//           i_rx            raw asynchronous serial line
//           i_clear         hold the tick counter at 0 (receiver idle)
//           o_rx_s          synchronized line
//           o_bit_val       majority-voted bit value (valid with o_bit_done)
//           o_bit_done      strobe on the tick-9 sample of the current bit
//           o_bit_end       strobe on the last tick (15) of the current bit
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ce,
  input  logic i_rx,
  input  logic i_clear,
  output logic o_rx_s,
  output logic o_bit_val,
  output logic o_bit_done,
  output logic o_bit_end
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_tick;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_rx_s;

  // Synchronizer runs every clock; presets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Tick counter wraps 15 -> 0 so consecutive bits need no explicit reload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else if (i_clear) begin
      r_tick <= '0;
    end else if (i_ce) begin
      r_tick <= r_tick + 4'd1;
      if (r_tick == c_TICK_S0) r_s0 <= w_rx_s;
      if (r_tick == c_TICK_S1) r_s1 <= w_rx_s;
    end
  end

  // Third sample is the live line value on tick 9.
  assign o_rx_s     = w_rx_s;
  assign o_bit_val  = maj3(r_s0, r_s1, w_rx_s);
  assign o_bit_done = i_ce && !i_clear && (r_tick == c_TICK_S2);
  assign o_bit_end  = i_ce && !i_clear && (r_tick == c_TICK_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module  : uart_rx
// Purpose : UART receiver. 16x oversampled, majority-voted bits, 6..9 data
//           bits, optional even/odd parity, one or two stop bits. Presents
//           each word with a one-clock strobe plus parity/frame error flags.
// Ports   : i_clk, i_rst_n  clock / async active-low reset
//           bus (master)    line, framing controls, received word/status
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  uart_rx_if.master bus
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_rx_s, w_bit_val, w_bit_done, w_bit_end;
  logic       w_start, w_shift, w_bit_adv, w_par_chk, w_stop_chk, w_finish;
  logic       w_busy, w_last_bit, w_ferr_final;
  rx_cfg_t    r_cfg;
  logic [8:0] r_shift;
  logic [8:0] r_data;
  logic [3:0] r_bitcnt;
  logic       r_perr, r_ferr;
  logic       r_valid, r_perr_o, r_ferr_o;
  logic       r_armed;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ce       (bus.i_ce),
    .i_rx       (bus.i_rx),
    .i_clear    (r_state == c_ST_IDLE),
    .o_rx_s     (w_rx_s),
    .o_bit_val  (w_bit_val),
    .o_bit_done (w_bit_done),
    .o_bit_end  (w_bit_end)
  );

  assign w_last_bit   = (r_bitcnt == (data_bits(r_cfg.length) - 4'd1));
  // The final stop bit is still on w_bit_val when the frame completes.
  assign w_ferr_final = r_ferr | ~w_bit_val;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (bus.i_ce && !w_rx_s && r_armed) w_next = c_ST_START;
      c_ST_START: begin
        if (w_bit_done && w_bit_val) w_next = c_ST_IDLE;   // false start
        else if (w_bit_end)          w_next = c_ST_DATA;
      end
      c_ST_DATA: begin
        if (w_bit_end && w_last_bit)
          w_next = r_cfg.parity ? c_ST_PARITY : c_ST_STOP1;
      end
      c_ST_PARITY: if (w_bit_end) w_next = c_ST_STOP1;
      c_ST_STOP1: begin
        // A lone stop bit ends the frame at its centre sample.
        if (r_cfg.stop2) begin
          if (w_bit_end) w_next = c_ST_STOP2;
        end else if (w_bit_done) begin
          w_next = c_ST_IDLE;
        end
      end
      c_ST_STOP2:  if (w_bit_done) w_next = c_ST_IDLE;
      default:     w_next = c_ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_bit_adv  = 1'b0;
    w_par_chk  = 1'b0;
    w_stop_chk = 1'b0;
    w_finish   = 1'b0;
    w_busy     = (r_state != c_ST_IDLE);
    w_start    = (r_state == c_ST_IDLE) && (w_next == c_ST_START);
    w_shift    = (r_state == c_ST_DATA) && w_bit_done;
    w_bit_adv  = (r_state == c_ST_DATA) && w_bit_end;
    w_par_chk  = (r_state == c_ST_PARITY) && w_bit_done;
    w_stop_chk = ((r_state == c_ST_STOP1) || (r_state == c_ST_STOP2)) && w_bit_done;
    w_finish   = w_stop_chk && (w_next == c_ST_IDLE);
  end

  // Datapath: config latch, word assembly, error tracking, result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_armed  <= 1'b1;
    end else begin
      r_valid <= w_finish;
      if (w_start) begin
        r_cfg    <= '{length: bus.i_length, stop2: bus.i_stop2,
                      parity: bus.i_parity, odd: bus.i_odd};
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_perr   <= 1'b0;
        r_ferr   <= 1'b0;
      end
      // Writing by index keeps the word LSB-aligned for every length.
      if (w_shift)   r_shift[r_bitcnt] <= w_bit_val;
      if (w_bit_adv) r_bitcnt <= r_bitcnt + 4'd1;
      // Unused upper bits of r_shift are zero, so a full reduction is safe.
      if (w_par_chk) r_perr <= (w_bit_val != (^r_shift ^ r_cfg.odd));
      if (w_stop_chk && !w_bit_val) r_ferr <= 1'b1;
      if (w_finish) begin
        r_data   <= r_shift;
        r_perr_o <= r_perr;
        r_ferr_o <= w_ferr_final;
      end
      // A break (zero word, low stop) disarms start detection until the
      // line is seen high again; otherwise a held-low line would retrigger.
      if (w_finish && w_ferr_final && (r_shift == '0)) r_armed <= 1'b0;
      else if (w_rx_s)                                 r_armed <= 1'b1;
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_parity_err = r_perr_o;
  assign bus.o_frame_err  = r_ferr_o;
  assign bus.o_busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx
// Purpose : Self-checking bench for uart_rx: directed vector table,
//           multi-cycle corner sequences and randomized frames against a
//           frame-level reference model.
// Ports   : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rx_ev_t;

  typedef struct {
    logic [8:0] d;
    logic [1:0] len;
    logic       s2, par, odd, flip, slow;
    logic [8:0] ed;
    logic       ep, ef;
  } vec_t;

  rx_ev_t     evq[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ce_per = 1;
  int         t_start = 0;
  int         busy_samples = 0;
  int         viol = 0;
  logic [8:0] prev_data = '0;
  logic       prev_perr = 1'b0, prev_ferr = 1'b0, prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Oversample tick generator: one tick every ce_per clocks.
  initial begin
    int cnt;
    cnt = 0;
    bus.i_ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1 >= ce_per) ? 0 : cnt + 1;
      bus.i_ce = (cnt == 0);
    end
  end

  // Monitor: capture strobes, flag outputs that move without o_valid,
  // strobes wider than one clock, and busy overlapping the strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_busy) busy_samples <= busy_samples + 1;
      if (bus.o_valid) begin
        evq.push_back('{bus.o_data, bus.o_parity_err, bus.o_frame_err, cyc});
        if (prev_valid || bus.o_busy) viol <= viol + 1;
      end else if (bus.o_data !== prev_data || bus.o_parity_err !== prev_perr ||
                   bus.o_frame_err !== prev_ferr) begin
        viol <= viol + 1;
      end
    end
    prev_data  <= bus.o_data;
    prev_perr  <= bus.o_parity_err;
    prev_ferr  <= bus.o_frame_err;
    prev_valid <= bus.o_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_cmp++;
    if (val < lo || val > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transmitter model: start, data LSB first, optional parity, stop bit(s).
  // Config inputs are scrambled after the start bit to show they are latched.
  task automatic send_frame(input logic [8:0] d, input logic [1:0] len, input logic s2,
                            input logic par, input logic odd, input logic flip,
                            input logic slow);
    logic bits[$];
    logic p;
    int   nbits;
    nbits = 6 + int'(len);
    p = odd;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (par) bits.push_back(p ^ flip);
    bits.push_back(~slow);
    if (s2) bits.push_back(1'b1);
    bus.i_length = len;
    bus.i_stop2  = s2;
    bus.i_parity = par;
    bus.i_odd    = odd;
    t_start = cyc;
    for (int i = 0; i < bits.size(); i++) begin
      bus.i_rx = bits[i];
      repeat (16 * ce_per) @(posedge clk);
      #1;
      if (i == 0) begin
        bus.i_length = 2'($urandom_range(0, 3));
        bus.i_stop2  = 1'($urandom_range(0, 1));
        bus.i_parity = 1'($urandom_range(0, 1));
        bus.i_odd    = 1'($urandom_range(0, 1));
      end
    end
    bus.i_rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [8:0] ed, input logic ep,
                              input logic ef, input int lo, input int hi);
    rx_ev_t ev;
    check({tag, " strobe count"}, evq.size(), 1);
    if (evq.size() != 0) begin
      ev = evq.pop_front();
      check({tag, " data"}, ev.data, ed);
      check({tag, " parity_err"}, ev.perr, ep);
      check({tag, " frame_err"}, ev.ferr, ef);
      if (lo >= 0) check_range({tag, " latency"}, ev.cyc - t_start, lo, hi);
    end
    evq.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " o_data"}, bus.o_data, 9'h000);
    check({tag, " o_valid"}, bus.o_valid, 1'b0);
    check({tag, " o_parity_err"}, bus.o_parity_err, 1'b0);
    check({tag, " o_frame_err"}, bus.o_frame_err, 1'b0);
    check({tag, " o_busy"}, bus.o_busy, 1'b0);
  endtask

  vec_t vt[8];

  initial begin
    int     nb;
    int     b0;
    rx_ev_t e1, e2;

    vt[0] = '{9'h069, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h069, 1'b0, 1'b0};
    vt[1] = '{9'h1A5, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1A5, 1'b0, 1'b0};
    vt[2] = '{9'h1A5, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h1A5, 1'b1, 1'b0};
    vt[3] = '{9'h03C, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1};
    vt[4] = '{9'h1FF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h03F, 1'b0, 1'b0};
    vt[5] = '{9'h0AB, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h02B, 1'b0, 1'b0};
    vt[6] = '{9'h155, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h155, 1'b1, 1'b0};
    vt[7] = '{9'h0C3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b1};

    bus.i_rx = 1'b1;
    bus.i_length = 2'd2;
    bus.i_stop2 = 1'b0;
    bus.i_parity = 1'b0;
    bus.i_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(40);

    // Directed table.
    foreach (vt[i]) begin
      ce_per = 1;
      send_frame(vt[i].d, vt[i].len, vt[i].s2, vt[i].par, vt[i].odd, vt[i].flip, vt[i].slow);
      idle(48);
      nb = 2 + 6 + int'(vt[i].len) + int'(vt[i].par) + int'(vt[i].s2);
      expect_frame($sformatf("vec%0d", i), vt[i].ed, vt[i].ep, vt[i].ef,
                   16 * (nb - 1) + 9, 16 * nb - 1);
    end

    // Break: line held low for two 8N1 frame times.
    bus.i_length = 2'd2; bus.i_stop2 = 1'b0; bus.i_parity = 1'b0; bus.i_odd = 1'b0;
    bus.i_rx = 1'b0;
    repeat (320) @(posedge clk);
    #1;
    expect_frame("break", 9'h000, 1'b0, 1'b1, -1, -1);
    idle(64);
    check("break after line high strobes", evq.size(), 0);
    send_frame(9'h0AA, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);
    expect_frame("rearm", 9'h0AA, 1'b0, 1'b0, -1, -1);

    // Short glitch: false start, busy for about ten clocks, no strobe.
    b0 = busy_samples;
    bus.i_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check("glitch strobes", evq.size(), 0);
    check_range("glitch busy clocks", busy_samples - b0, 8, 12);
    check("glitch busy after", bus.o_busy, 1'b0);

    // Back-to-back 8N1 frames with no idle gap.
    send_frame(9'h055, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(9'h0AA, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);
    check("b2b strobe count", evq.size(), 2);
    if (evq.size() >= 2) begin
      e1 = evq.pop_front();
      e2 = evq.pop_front();
      check("b2b first data", e1.data, 9'h055);
      check("b2b second data", e2.data, 9'h0AA);
      check("b2b spacing", e2.cyc - e1.cyc, 160);
    end
    evq.delete();

    // Asynchronous reset in the middle of the data bits.
    bus.i_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    bus.i_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("pre-reset busy", bus.o_busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(48);
    check("partial word strobes", evq.size(), 0);
    send_frame(9'h0F0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);
    expect_frame("post-reset", 9'h0F0, 1'b0, 1'b0, -1, -1);

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 30; k++) begin
      logic [8:0] d, ed;
      logic [1:0] len;
      logic       s2, par, odd, flip, slow;
      d    = 9'($urandom);
      len  = 2'($urandom_range(0, 3));
      s2   = 1'($urandom_range(0, 1));
      par  = 1'($urandom_range(0, 1));
      odd  = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0);
      slow = ($urandom_range(0, 7) == 0);
      ce_per = $urandom_range(1, 3);
      ed = d & 9'((1 << (6 + int'(len))) - 1);
      send_frame(d, len, s2, par, odd, flip, slow);
      if (slow && !s2) idle(48 * ce_per);
      else             idle($urandom_range(0, 3));
      expect_frame($sformatf("rnd%0d", k), ed, par & flip, slow, -1, -1);
    end

    idle(8);
    check("output stability violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
